nfa_stream_ctrl: RTL and testbench
==================================

Name: nfa_stream_ctrl

Overview:
Sequencer that feeds a packetised byte stream to a bank of NUM_ENG NFA regex engines sharing one char/en/sod bus.
- Clears all engines at start of data (sod) and drives one char per accepted beat.
- Flushes the engine pipelines after the last byte, then captures the sticky match vector.
- Returns one result record per packet over a valid/ready handshake.

Parameters:
NUM_ENG, 8, number of engines on the shared bus (1..64)
CNT_W, 16, width of packet length counter
DRAIN_CYC, 1, flush cycles after last byte, = deepest engine pipeline minus 1 (1..15)
FLUSH_CHAR, 8'h00, byte driven during flush; engine compiler guarantees it is outside every engine's character classes

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat accept
s_data  in  8  input byte
s_first  in  1  first byte of packet
s_last  in  1  last byte of packet
eng_char  out  8  char bus to engines
eng_en  out  1  engine enable
eng_sod  out  1  engine clear (active high, engines' rst/sod pin)
eng_match  in  NUM_ENG  engine out bits, bit i = engine i
r_valid  out  1  result valid
r_ready  in  1  result accept
r_match  out  NUM_ENG  captured match vector
r_any  out  1  OR of r_match
r_len  out  CNT_W  bytes in packet, saturating
busy  out  1  state != IDLE

Behaviour:
- Clock is clk. Reset is rst: one clock, synchronous, active-low.
- Reset (rst=0, any state): next edge -> IDLE. r_valid=0, r_match=0, r_len=0, length counter=0, drain counter=0. While rst=0: eng_sod=1, eng_en=0, eng_char=0, s_ready=0.
- Handshakes: beat accepted when s_valid&s_ready. Result accepted when r_valid&r_ready. r_valid, once high, holds with r_match/r_len/r_any stable until accepted.
- FSM states: IDLE, CLEAR, RUN, DRAIN, CAPTURE, REPORT.
- IDLE:
  - s_ready = ~s_first. Non-first beats are consumed and discarded (eng_en=0).
  - s_valid&s_first -> CLEAR. The beat is not consumed.
- CLEAR (1 cycle): eng_sod=1, eng_en=0, s_ready=0, length counter<=0 -> RUN.
- RUN:
  - s_ready=1. eng_en = s_valid, eng_char = s_data (combinational, zero latency).
  - Each accepted beat increments the length counter, saturating at 2^CNT_W-1.
  - s_first inside RUN is ignored; the beat is treated as data.
  - Accepted beat with s_last=1 -> DRAIN. A first&last single beat is legal.
- DRAIN (exactly DRAIN_CYC cycles): eng_en=1, eng_char=FLUSH_CHAR, s_ready=0 -> CAPTURE.
- CAPTURE (1 cycle): eng_en=0, r_match<=eng_match, r_len<=length counter -> REPORT.
- REPORT: r_valid=1, s_ready=0, eng_en=0. Result accept -> IDLE.
- eng_sod=0 and eng_en=0 outside the cases above. eng_char=0 whenever eng_en=0.
- r_any = |r_match.
- Latency: last-byte accept at cycle t -> r_valid high at t+DRAIN_CYC+2.
- Overhead per packet: 1 CLEAR + DRAIN_CYC + 1 CAPTURE + at least 1 REPORT cycle.
- Back-to-back packets: a first beat presented during REPORT stalls, enters CLEAR the cycle after IDLE is reached, then is accepted in RUN.
- s_valid low mid-packet in RUN: eng_en=0, engines hold state, no timeout.

Test Plan:
- Reset: rst=0 for 3 cycles with s_valid=1,s_first=1 -> s_ready=0, eng_sod=1, eng_en=0, r_valid=0, busy=0. First edge after release: IDLE; next edge: CLEAR.
- Basic packet: NUM_ENG=2, engine0 models /m|n/i (2-stage), engine1 models /z/. Send "xMy" (first on 'x', last on 'y') -> one sod cycle; 3 en cycles with chars 0x78,0x4D,0x79; 1 flush cycle with 0x00; r_valid 3 cycles after 'y' accepted with r_match=2'b01, r_any=1, r_len=3.
- Result backpressure: r_ready=0 for 5 cycles, next packet's first beat waiting -> r_valid held, r_match/r_len stable, s_ready=0. Raise r_ready -> IDLE, CLEAR, then first beat accepted.
- Stray beats: in IDLE send 0x41,0x42 with s_first=0 -> both accepted (s_ready=1), eng_en=0, no report. Then single beat 'n' with first&last -> r_len=1, r_match=2'b01.
- Mid-packet reset: rst=0 for 1 cycle after 2 RUN beats -> IDLE next edge, no r_valid. Following packet "zz" -> r_match=2'b10, r_len=2, no carry-over.
- Saturation/gaps (CNT_W=4): 20-beat packet with s_valid gaps every 3rd cycle -> eng_en only on accepted beats; r_len=15.

Source files
------------

// File: rtl/nfa_stream_ctrl.sv
// Stream sequencer for a bank of NFA regex engines sharing one char/en/sod bus.
// Clears the engines per packet, feeds bytes, flushes, captures the match vector and reports it.
module nfa_stream_ctrl #(
   parameter int          NUM_ENG    = 8,
   parameter int          CNT_W      = 16,
   parameter int          DRAIN_CYC  = 1,
   parameter logic [7:0]  FLUSH_CHAR = 8'h00
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [7:0]         s_data,
   input  logic               s_first,
   input  logic               s_last,
   output logic [7:0]         eng_char,
   output logic               eng_en,
   output logic               eng_sod,
   input  logic [NUM_ENG-1:0] eng_match,
   output logic               r_valid,
   input  logic               r_ready,
   output logic [NUM_ENG-1:0] r_match,
   output logic               r_any,
   output logic [CNT_W-1:0]   r_len,
   output logic               busy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      RUN     = 3'd2,
      DRAIN   = 3'd3,
      CAPTURE = 3'd4,
      REPORT  = 3'd5
   } state_t;

   localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   len_cnt;
   logic [3:0]         drain_cnt;
   logic               beat_acc;

   // Length counter sticks at all-ones instead of wrapping on oversize packets.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v)
         return v;
      return v + 1'b1;
   endfunction

   assign beat_acc = s_valid & s_ready;

   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      eng_en    = 1'b0;
      eng_char  = 8'h00;
      eng_sod   = 1'b0;
      case (state)
         IDLE: begin
            // Stray non-first beats are swallowed; a first beat waits for CLEAR.
            s_ready = ~s_first;
            if (s_valid && s_first)
               state_nxt = CLEAR;
         end
         CLEAR: begin
            eng_sod   = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            s_ready = 1'b1;
            eng_en  = s_valid;
            if (s_valid)
               eng_char = s_data;
            if (s_valid && s_last)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            eng_en   = 1'b1;
            eng_char = FLUSH_CHAR;
            if (drain_cnt == DRAIN_LAST)
               state_nxt = CAPTURE;
         end
         CAPTURE: begin
            state_nxt = REPORT;
         end
         REPORT: begin
            if (r_ready)
               state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      // Engines are held in clear and the input is stalled for as long as reset is asserted.
      if (!rst) begin
         s_ready   = 1'b0;
         eng_en    = 1'b0;
         eng_char  = 8'h00;
         eng_sod   = 1'b1;
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         len_cnt   <= '0;
         drain_cnt <= '0;
         r_match   <= '0;
         r_len     <= '0;
      end else begin
         case (state)
            CLEAR: begin
               len_cnt <= '0;
            end
            RUN: begin
               drain_cnt <= '0;
               if (beat_acc)
                  len_cnt <= sat_inc(len_cnt);
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + 4'd1;
            end
            CAPTURE: begin
               r_match <= eng_match;
               r_len   <= len_cnt;
            end
            default: begin
            end
         endcase
      end
   end

   assign r_valid = (state == REPORT);
   assign r_any   = |r_match;
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_nfa_stream_ctrl.sv
// Self-checking bench for nfa_stream_ctrl: two engine models (/m|n/i and /z/), a result
// scoreboard, a packet vector table and hand sequences for reset, backpressure and gaps.
module tb_nfa_stream_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_first = 1'b0;
   logic       s_last = 1'b0;
   logic       r_ready = 1'b1;

   logic        s_ready, eng_en, eng_sod, r_valid, r_any, busy;
   logic [7:0]  eng_char;
   logic [1:0]  eng_match, r_match;
   logic [15:0] r_len;

   logic        sm_s_ready, sm_eng_en, sm_eng_sod, sm_r_valid, sm_r_any, sm_busy;
   logic [7:0]  sm_eng_char;
   logic [1:0]  sm_eng_match, sm_r_match;
   logic [3:0]  sm_r_len;

   always #5 clk = ~clk;

   nfa_stream_ctrl #(.NUM_ENG(2), .CNT_W(16), .DRAIN_CYC(1), .FLUSH_CHAR(8'h00)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_first(s_first), .s_last(s_last), .eng_char(eng_char), .eng_en(eng_en),
      .eng_sod(eng_sod), .eng_match(eng_match), .r_valid(r_valid), .r_ready(r_ready),
      .r_match(r_match), .r_any(r_any), .r_len(r_len), .busy(busy));

   nfa_stream_ctrl #(.NUM_ENG(2), .CNT_W(4), .DRAIN_CYC(1), .FLUSH_CHAR(8'h00)) dut_sm (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sm_s_ready), .s_data(s_data),
      .s_first(s_first), .s_last(s_last), .eng_char(sm_eng_char), .eng_en(sm_eng_en),
      .eng_sod(sm_eng_sod), .eng_match(sm_eng_match), .r_valid(sm_r_valid), .r_ready(r_ready),
      .r_match(sm_r_match), .r_any(sm_r_any), .r_len(sm_r_len), .busy(sm_busy));

   // Two-stage engine models: bit0 = /m|n/i, bit1 = /z/, sticky until sod.
   function automatic logic [1:0] cls(input logic [7:0] c);
      cls[0] = (c == 8'h6D) || (c == 8'h4D) || (c == 8'h6E) || (c == 8'h4E);
      cls[1] = (c == 8'h7A);
   endfunction

   logic [1:0] hit_a, hit_b;

   always_ff @(posedge clk) begin
      if (eng_sod) begin
         hit_a     <= 2'b00;
         eng_match <= 2'b00;
      end else begin
         hit_a     <= eng_en ? cls(eng_char) : 2'b00;
         eng_match <= eng_match | hit_a;
      end
   end

   always_ff @(posedge clk) begin
      if (sm_eng_sod) begin
         hit_b        <= 2'b00;
         sm_eng_match <= 2'b00;
      end else begin
         hit_b        <= sm_eng_en ? cls(sm_eng_char) : 2'b00;
         sm_eng_match <= sm_eng_match | hit_b;
      end
   end

   typedef struct packed {
      logic [1:0]  m;
      logic [15:0] len;
   } exp_t;

   typedef struct {
      logic [31:0] d;
      int          n;
      logic [1:0]  m;
      int          len;
   } vec_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [7:0] en_log[$];
   int n_cmp = 0;
   int n_bad = 0;
   int n_rep = 0;
   int want_rep = 0;
   int sod_n = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int rv_cyc = 0;
   logic rv_prev = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst && eng_en)
         en_log.push_back(eng_char);
      if (rst && eng_sod)
         sod_n++;
      if (r_valid && !rv_prev)
         rv_cyc = cyc;
      rv_prev = r_valid;
   end

   // Scoreboard: one expected record per packet, popped at each result handshake.
   always @(negedge clk) begin
      if (rst && r_valid && r_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: actual r_match=%0h r_len=%0d, required no result", r_match, r_len);
         end else begin
            mon_e = exp_q.pop_front();
            chk("r_match", 64'(r_match), 64'(mon_e.m));
            chk("r_any", 64'(r_any), 64'(|mon_e.m));
            chk("r_len", 64'(r_len), 64'(mon_e.len));
            chk("sm_r_valid", 64'(sm_r_valid), 64'd1);
            chk("sm_r_match", 64'(sm_r_match), 64'(mon_e.m));
            chk("sm_r_len", 64'(sm_r_len), (mon_e.len > 16'd15) ? 64'd15 : 64'(mon_e.len));
         end
         n_rep++;
      end
   end

   task automatic send_beat(input logic [7:0] d, input logic f, input logic l);
      int k;
      k = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_first = f;
      s_last  = l;
      forever begin
         @(negedge clk);
         if (s_ready) begin
            acc_cyc = cyc;
            break;
         end
         k++;
         if (k > 50) begin
            chk("beat_accept_timeout", 64'(s_ready), 64'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_first = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_reports(input int target);
      int k;
      k = 0;
      while (n_rep < target && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("report_count", 64'(n_rep), 64'(target));
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input logic [31:0] d, input int n, input logic [1:0] m, input int len);
      exp_q.push_back('{m: m, len: 16'(len)});
      for (int j = 0; j < n; j++)
         send_beat(d[8*j +: 8], j == 0, j == n - 1);
      want_rep++;
      wait_reports(want_rep);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl[6];
      int   k;
      logic [7:0] gd;
      tbl[0] = '{d: 32'h0063_6261, n: 3, m: 2'b00, len: 3};
      tbl[1] = '{d: 32'h0000_004E, n: 1, m: 2'b01, len: 1};
      tbl[2] = '{d: 32'h0000_5A7A, n: 2, m: 2'b10, len: 2};
      tbl[3] = '{d: 32'h0000_7A6D, n: 2, m: 2'b11, len: 2};
      tbl[4] = '{d: 32'h0000_715A, n: 2, m: 2'b00, len: 2};
      tbl[5] = '{d: 32'h6E63_6261, n: 4, m: 2'b01, len: 4};

      // Reset held three cycles with a first beat waiting.
      rst = 1'b0; s_valid = 1'b1; s_first = 1'b1; s_last = 1'b1; s_data = 8'h78;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_s_ready", 64'(s_ready), 64'd0);
         chk("rst_eng_sod", 64'(eng_sod), 64'd1);
         chk("rst_eng_en", 64'(eng_en), 64'd0);
         chk("rst_eng_char", 64'(eng_char), 64'd0);
         chk("rst_r_valid", 64'(r_valid), 64'd0);
         if (i > 0) begin
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_r_len", 64'(r_len), 64'd0);
            chk("rst_r_match", 64'(r_match), 64'd0);
         end
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      exp_q.push_back('{m: 2'b00, len: 16'd1});
      @(negedge clk);
      chk("rel_idle_busy", 64'(busy), 64'd0);
      chk("rel_idle_s_ready", 64'(s_ready), 64'd0);
      chk("rel_idle_sod", 64'(eng_sod), 64'd0);
      @(negedge clk);
      chk("rel_clear_sod", 64'(eng_sod), 64'd1);
      chk("rel_clear_busy", 64'(busy), 64'd1);
      chk("rel_clear_s_ready", 64'(s_ready), 64'd0);
      send_beat(8'h78, 1'b1, 1'b1);
      want_rep++;
      wait_reports(want_rep);

      // Basic packet "xMy" with bus trace and latency.
      en_log.delete();
      sod_n = 0;
      send_pkt(32'h0079_4D78, 3, 2'b01, 3);
      chk("basic_sod_cycles", 64'(sod_n), 64'd1);
      chk("basic_en_cycles", 64'(en_log.size()), 64'd4);
      if (en_log.size() == 4) begin
         chk("basic_char0", 64'(en_log[0]), 64'h78);
         chk("basic_char1", 64'(en_log[1]), 64'h4D);
         chk("basic_char2", 64'(en_log[2]), 64'h79);
         chk("basic_flush", 64'(en_log[3]), 64'h00);
      end
      chk("basic_latency", 64'(rv_cyc - acc_cyc), 64'd3);

      // Packet vector table.
      for (int i = 0; i < 6; i++)
         send_pkt(tbl[i].d, tbl[i].n, tbl[i].m, tbl[i].len);

      // Result backpressure with the next first beat waiting.
      r_ready = 1'b0;
      exp_q.push_back('{m: 2'b00, len: 16'd2});
      send_beat(8'h61, 1'b1, 1'b0);
      send_beat(8'h62, 1'b0, 1'b1);
      k = 0;
      while (!r_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("bp_r_valid_rise", 64'(r_valid), 64'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b1; s_first = 1'b1; s_last = 1'b1; s_data = 8'h7A;
      exp_q.push_back('{m: 2'b10, len: 16'd1});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_r_valid", 64'(r_valid), 64'd1);
         chk("bp_r_match", 64'(r_match), 64'd0);
         chk("bp_r_len", 64'(r_len), 64'd2);
         chk("bp_s_ready", 64'(s_ready), 64'd0);
         chk("bp_eng_en", 64'(eng_en), 64'd0);
         @(posedge clk);
         #1;
      end
      r_ready = 1'b1;
      @(negedge clk);
      chk("bp_acc_s_ready", 64'(s_ready), 64'd0);
      @(negedge clk);
      chk("bp_idle_busy", 64'(busy), 64'd0);
      chk("bp_idle_s_ready", 64'(s_ready), 64'd0);
      @(negedge clk);
      chk("bp_clear_sod", 64'(eng_sod), 64'd1);
      @(negedge clk);
      chk("bp_run_s_ready", 64'(s_ready), 64'd1);
      chk("bp_run_eng_en", 64'(eng_en), 64'd1);
      chk("bp_run_char", 64'(eng_char), 64'h7A);
      @(posedge clk);
      #1;
      s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
      want_rep += 2;
      wait_reports(want_rep);

      // Stray beats in IDLE are consumed without reaching the engines.
      s_valid = 1'b1; s_first = 1'b0; s_last = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s_data = 8'h41 + 8'(i);
         @(negedge clk);
         chk("stray_s_ready", 64'(s_ready), 64'd1);
         chk("stray_eng_en", 64'(eng_en), 64'd0);
         chk("stray_busy", 64'(busy), 64'd0);
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("stray_no_report", 64'(n_rep), 64'(want_rep));
      chk("stray_idle", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      send_pkt(32'h0000_006E, 1, 2'b01, 1);

      // Reset in the middle of a packet.
      send_beat(8'h7A, 1'b1, 1'b0);
      send_beat(8'h7A, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_sod", 64'(eng_sod), 64'd1);
      chk("midrst_en", 64'(eng_en), 64'd0);
      chk("midrst_s_ready", 64'(s_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_r_valid", 64'(r_valid), 64'd0);
      repeat (4) @(negedge clk);
      chk("midrst_no_report", 64'(n_rep), 64'(want_rep));
      @(posedge clk);
      #1;
      send_pkt(32'h0000_7A7A, 2, 2'b10, 2);

      // 20-beat packet with a gap every third cycle; length saturates on the 4-bit instance.
      exp_q.push_back('{m: 2'b01, len: 16'd20});
      send_beat(8'h30, 1'b1, 1'b0);
      begin
         int i;
         int c;
         i = 1;
         c = 0;
         while (i < 20 && c < 100) begin
            if (c % 3 == 2) begin
               s_valid = 1'b0;
            end else begin
               gd = (i == 19) ? 8'h6D : 8'h30 + 8'(i);
               s_valid = 1'b1;
               s_data  = gd;
               s_last  = (i == 19);
            end
            @(negedge clk);
            chk("gap_eng_en", 64'(eng_en), 64'(s_valid));
            if (s_valid) begin
               chk("gap_char", 64'(eng_char), 64'(s_data));
               chk("gap_s_ready", 64'(s_ready), 64'd1);
            end
            @(posedge clk);
            #1;
            if (s_valid)
               i++;
            c++;
         end
         s_valid = 1'b0;
         s_last  = 1'b0;
      end
      want_rep++;
      wait_reports(want_rep);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
